// File: rtl/rep3_tx.sv
// rep3_tx: triple-repetition serial transmitter.
//
// Accepts a DATA_W-bit word over a valid/ready handshake. It sends the word
// LSB-first on a 1-bit stream, with each bit repeated as three consecutive
// copies so that a downstream majority voter can correct one bad copy.
//
// Optional feature macro: REP3_TX_PARITY_EN
//   When defined, one even-parity bit (XOR of the captured word) follows the
//   data bits and is also sent as three copies. FRAME_BITS is then DATA_W+1.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   din        in   parallel word to send
//   din_valid  in   din is valid
//   din_ready  out  word can be accepted (IDLE only)
//   tx         out  current serial copy
//   tx_valid   out  tx carries a copy
//   tx_ready   in   channel accepts the current copy
//   tx_copy    out  copy index 0..2 of the current bit
//   tx_last    out  current copy is the final copy of the frame
module rep3_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [1:0]        tx_copy,
    output logic              tx_last
);

`ifdef REP3_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 1;
`else
    localparam int FRAME_BITS = DATA_W;
`endif
    localparam int BCW = $clog2(DATA_W + 2);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic [1:0]            copy_q, copy_d;
    logic                  tx_q, tx_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [1:0]            tx_copy_q, tx_copy_d;
    logic                  tx_last_q, tx_last_d;
    logic                  xfer;

    assign xfer      = tx_valid_q && tx_ready;
    assign din_ready = (state_q == IDLE);
    assign tx        = tx_q;
    assign tx_valid  = tx_valid_q;
    assign tx_copy   = tx_copy_q;
    assign tx_last   = tx_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            bit_q      <= '0;
            copy_q     <= '0;
            tx_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_copy_q  <= 2'd0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            copy_q     <= copy_d;
            tx_q       <= tx_d;
            tx_valid_q <= tx_valid_d;
            tx_copy_q  <= tx_copy_d;
            tx_last_q  <= tx_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        copy_d  = copy_q;
        case (state_q)
            IDLE: begin
                if (din_valid) begin
`ifdef REP3_TX_PARITY_EN
                    sh_d = {^din, din};
`else
                    sh_d = din;
`endif
                    bit_d   = '0;
                    copy_d  = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (copy_q == 2'd2) begin
                        copy_d = 2'd0;
                        sh_d   = sh_q >> 1;
                        bit_d  = bit_q + 1'b1;
                    end else begin
                        copy_d = copy_q + 2'd1;
                    end
                    if (tx_last_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: load them from the next-state values so
        // they line up with the state they describe.
        tx_valid_d = (state_d == SEND);
        tx_d       = (state_d == SEND) && sh_d[0];
        tx_copy_d  = copy_d;
        tx_last_d  = (state_d == SEND) && (bit_d == LAST_BIT) && (copy_d == 2'd2);
    end

endmodule

// File: tb/tb_rep3_tx.sv
module tb_rep3_tx;

`ifdef REP3_TX_PARITY_EN
    localparam int F = 9;
`else
    localparam int F = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       tx;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [1:0] tx_copy;
    logic       tx_last;

    int checks = 0;
    int errors = 0;

    rep3_tx #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .tx(tx), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_copy(tx_copy), .tx_last(tx_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int i);
        if (i < 8) return w[i];
        return ^w;
    endfunction

    // Accept a word: din_valid high across one edge while IDLE.
    task automatic accept(input logic [7:0] w);
        chk("ready_before_accept", din_ready, 1);
        din = w;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    // Check every copy of a frame; optionally stall 5 cycles on copy stall_at.
    task automatic run_frame(input string tag, input logic [7:0] w, input int stall_at);
        for (int k = 0; k < 3 * F; k++) begin
            if (k == stall_at) begin
                tx_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    chk({tag, "_stall_tx"}, tx, exp_bit(w, k / 3));
                    chk({tag, "_stall_copy"}, tx_copy, 32'(k % 3));
                    chk({tag, "_stall_valid"}, tx_valid, 1);
                end
                tx_ready = 1'b1;
            end
            chk({tag, "_valid"}, tx_valid, 1);
            chk({tag, "_ready"}, din_ready, 0);
            chk({tag, "_tx"}, tx, exp_bit(w, k / 3));
            chk({tag, "_copy"}, tx_copy, 32'(k % 3));
            chk({tag, "_last"}, tx_last, (k == 3 * F - 1) ? 1 : 0);
            step();
        end
        chk({tag, "_idle_ready"}, din_ready, 1);
        chk({tag, "_idle_valid"}, tx_valid, 0);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", din_ready, 1);
        chk("rst_valid", tx_valid, 0);
        chk("rst_tx", tx, 0);
        chk("rst_copy", tx_copy, 0);
        chk("rst_last", tx_last, 0);
        step();
        rst = 1'b0;
        step();

        // Single word A5: 111 000 111 000 000 111 000 111 (+ parity 000)
        accept(8'hA5);
        run_frame("a5", 8'hA5, -1);

        // Backpressure on the second copy of bit 0
        accept(8'h01);
        run_frame("bp", 8'h01, 1);

        // din_valid held with FF during a frame of 00
        din = 8'h00;
        din_valid = 1'b1;
        step();
        din = 8'hFF;
        run_frame("ign", 8'h00, -1);
        step();
        din_valid = 1'b0;
        run_frame("ff", 8'hFF, -1);

        // Reset mid-frame after 10 transfers
        accept(8'hA5);
        for (int k = 0; k < 10; k++) step();
        chk("mid_valid_pre", tx_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", din_ready, 1);
        chk("mid_rst_valid", tx_valid, 0);
        chk("mid_rst_tx", tx, 0);
        chk("mid_rst_copy", tx_copy, 0);
        chk("mid_rst_last", tx_last, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_valid", tx_valid, 0);
        accept(8'h3C);
        run_frame("3c", 8'h3C, -1);

`ifdef REP3_TX_PARITY_EN
        // Odd-weight word: parity copies are 1
        accept(8'h07);
        run_frame("p07", 8'h07, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
